// File: rtl/us_range_pkg.sv
// us_range_pkg: shared state encoding, widths and cycle-count helpers for the ultrasonic ranger
package us_range_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  localparam int DIS_W = 9;
  function automatic int us_cyc(input longint us, input longint clk_hz);
    return int'(us * clk_hz / 64'd1_000_000);
  endfunction
  localparam int TRIG_CYC = us_cyc(10, 50_000_000);
  localparam int CM_CYC = us_cyc(58, 50_000_000);
  localparam int TIMEOUT_CYC = us_cyc(25_000, 50_000_000);
  localparam int PERIOD_CYC = us_cyc(60_000, 50_000_000);
endpackage

// File: rtl/us_range_avg4.sv
// us_range_avg4: 4-sample moving average of good distances; first sample primes the whole history
module us_range_avg4 import us_range_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIS_W-1:0] sample,
  output logic [DIS_W-1:0] avg
);
  logic [DIS_W-1:0] h0, h1, h2;
  logic primed;
  logic [DIS_W+1:0] sum;
  // average includes the incoming sample so the result is ready in the same cycle it is loaded
  always_comb begin
    sum = primed ? 11'(sample) + 11'(h0) + 11'(h1) + 11'(h2) : {sample, 2'b00};
    avg = sum[DIS_W+1:2];
  end
  // shift history on each good result; the first one fills every slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
      primed <= 1'b0;
    end else if (load) begin
      h0 <= sample;
      h1 <= primed ? h0 : sample;
      h2 <= primed ? h1 : sample;
      primed <= 1'b1;
    end
endmodule

// File: rtl/us_range_ctrl.sv
// us_range_ctrl: HC-SR04 trigger/echo timer producing whole-cm distance; define US_RANGE_AVG_EN for 4-sample averaging
module us_range_ctrl import us_range_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int TRIG_US = 10,
  parameter int PERIOD_MS = 60,
  parameter int TIMEOUT_US = 25000,
  parameter int MAX_CM = 400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             echo,
  output logic             trig,
  output logic [DIS_W-1:0] dis,
  output logic             dis_valid,
  output logic             timeout
);
  localparam logic [31:0] TRIG_N = 32'(us_cyc(TRIG_US, CLK_HZ));
  localparam logic [31:0] CM_N = 32'(us_cyc(58, CLK_HZ));
  localparam logic [31:0] TO_N = 32'(us_cyc(TIMEOUT_US, CLK_HZ));
  localparam logic [31:0] PER_N = 32'(us_cyc(longint'(PERIOD_MS) * 1000, CLK_HZ));
  localparam logic [DIS_W-1:0] MAX_V = DIS_W'(MAX_CM);
  state_t state;
  logic [2:0] sync;
  logic rise, fall;
  logic [31:0] cnt, presc, period_cnt;
  logic [DIS_W-1:0] cm_cnt, raw, new_dis;
  logic good, wrap;
  assign raw = cm_cnt > MAX_V ? MAX_V : cm_cnt;
  assign good = state == MEASURE && fall;
  assign wrap = presc == CM_N - 1;
`ifdef US_RANGE_AVG_EN
  us_range_avg4 u_avg (.clk(clk), .rst_n(rst_n), .load(good), .sample(raw), .avg(new_dis));
`else
  assign new_dis = raw;
`endif
  // two-flop synchroniser followed by registered rise/fall detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[1:0], echo};
      rise <= sync[1] & ~sync[2];
      fall <= ~sync[1] & sync[2];
    end
  // measurement sequencer; cnt is the per-state timer and, in MEASURE, the echo-high cycle count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      trig <= 1'b0;
      dis <= '0;
      dis_valid <= 1'b0;
      timeout <= 1'b0;
      cnt <= '0;
      presc <= '0;
      period_cnt <= '0;
      cm_cnt <= '0;
    end else begin
      dis_valid <= 1'b0;
      period_cnt <= state == IDLE ? '0 : period_cnt + 1;
      case (state)
        IDLE: if (en) begin
          state <= TRIG;
          trig <= 1'b1;
          cnt <= '0;
        end
        TRIG: if (cnt == TRIG_N - 1) begin
          state <= WAIT_RISE;
          trig <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 1;
        WAIT_RISE: if (rise) begin
          state <= MEASURE;
          cnt <= 32'd1;
          presc <= 32'd1;
          cm_cnt <= '0;
        end else if (cnt == TO_N - 1) begin
          state <= HOLDOFF;
          timeout <= 1'b1;
        end else cnt <= cnt + 1;
        MEASURE: if (fall) begin
          state <= HOLDOFF;
          dis <= new_dis;
          dis_valid <= 1'b1;
          timeout <= 1'b0;
        end else if (cnt == TO_N) begin
          state <= HOLDOFF;
          timeout <= 1'b1;
        end else begin
          cnt <= cnt + 1;
          presc <= wrap ? '0 : presc + 1;
          cm_cnt <= cm_cnt + DIS_W'(wrap && !(&cm_cnt));
        end
        HOLDOFF: if (period_cnt >= PER_N - 2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_us_range_ctrl.sv
// tb_us_range_ctrl: directed scoreboard bench for us_range_ctrl with shortened timing parameters
`timescale 1ns/1ps
module tb_us_range_ctrl;
  localparam int CM = 58, TO = 2000, PER = 5000, TRW = 10, MAXC = 30;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, echo = 1'b0;
  logic trig, dis_valid, timeout;
  logic [8:0] dis;
  int checks = 0, failures = 0;
  int cyc = 0, n_rises = 0, n_falls = 0, t_rise = 0, t_prev_rise = 0, trig_w = 0;
  int n_valid = 0, exp_valid = 0, last_dis = 0, e_val = 0, r0 = 0;
  logic trig_d = 1'b0;
  int exp_q[$];
  int hist[$];

  us_range_ctrl #(.CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(5), .TIMEOUT_US(2000), .MAX_CM(30)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .echo(echo),
    .trig(trig), .dis(dis), .dis_valid(dis_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (trig && !trig_d) begin
      t_prev_rise = t_rise;
      t_rise = cyc;
      n_rises++;
    end
    if (!trig && trig_d) begin
      trig_w = cyc - t_rise;
      n_falls++;
    end
    trig_d = trig;
    if (dis_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_valid observed dis=%0d expected no pulse", dis);
      end else begin
        e_val = exp_q.pop_front();
        chk("dis_value", 32'(dis), e_val);
        chk("timeout_on_valid", 32'(timeout), 0);
      end
    end
  end

  task automatic push_exp(input int raw);
    int r, s;
    r = raw > MAXC ? MAXC : raw;
`ifdef US_RANGE_AVG_EN
    if (hist.size() == 0) repeat (4) hist.push_back(r);
    else begin
      hist.push_front(r);
      void'(hist.pop_back());
    end
    s = 0;
    foreach (hist[i]) s += hist[i];
    last_dis = s / 4;
`else
    s = r;
    last_dis = s;
`endif
    exp_q.push_back(last_dis);
    exp_valid++;
  endtask

  task automatic wait_fall();
    int s, k;
    s = n_falls;
    k = 0;
    while (n_falls == s && k < 20000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("trig_fall_seen", n_falls - s, 1);
  endtask

  task automatic meas(input int n);
    bit good;
    good = n > 0 && n <= TO;
    wait_fall();
    repeat (20) @(negedge clk);
    if (good) push_exp(n / CM);
    if (n > 0) begin
      echo = 1'b1;
      repeat (n) @(negedge clk);
      echo = 1'b0;
    end
    repeat (10) @(negedge clk);
    #1;
    chk("valid_count", n_valid, exp_valid);
    chk("timeout_flag", 32'(timeout), 32'(!good));
    chk("dis_held", 32'(dis), last_dis);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_dis", 32'(dis), 0);
    chk("rst_valid", 32'(dis_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    #1;
    chk("trig_latency", 32'(trig), 1);
    meas(20 * CM);
    chk("trig_width", trig_w, TRW);
    meas(20 * CM + CM - 1);
    chk("trig_period", t_rise - t_prev_rise, PER);
    meas(1800);
    wait_fall();
    repeat (TO - 1) @(negedge clk);
    #1;
    chk("wait_to_early", 32'(timeout), 0);
    @(negedge clk);
    #1;
    chk("wait_to_set", 32'(timeout), 1);
    chk("wait_to_dis_held", 32'(dis), last_dis);
    chk("wait_to_no_valid", n_valid, exp_valid);
    meas(TO);
    meas(TO + 1);
    meas(5 * CM);
    en = 1'b0;
    r0 = n_rises;
    repeat (8000) @(negedge clk);
    #1;
    chk("en_off_no_trig", n_rises, r0);
    en = 1'b1;
    wait_fall();
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_dis", 32'(dis), 0);
    chk("arst_valid", 32'(dis_valid), 0);
    chk("arst_timeout", 32'(timeout), 0);
    echo = 1'b0;
    en = 1'b0;
    hist.delete();
    last_dis = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(trig), 0);
    en = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_trig", 32'(trig), 1);
    echo = 1'b1;
    wait_fall();
    repeat (50) @(negedge clk);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    push_exp(5);
    echo = 1'b1;
    repeat (5 * CM) @(negedge clk);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("early_echo_valid_count", n_valid, exp_valid);
    chk("early_echo_dis", 32'(dis), last_dis);
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
